// File: rtl/sobel_edge_det.sv
// Streaming 3x3 Sobel edge detector with RGB pass-through aligned to the window centre.
// Optional macro EDGE_MAG_OUT_EN adds the saturated magnitude output oMAG.
module sobel_edge_det #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iDVAL,
  input  logic       iSOF,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic [7:0] iTHRESH,
  output logic       oDVAL,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic [7:0] oEDG
`ifdef EDGE_MAG_OUT_EN
  ,
  output logic [7:0] oMAG
`endif
);

  localparam int unsigned RowW  = $clog2(IMG_HEIGHT);
  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ColLast    = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]   RowLast    = RowW'(IMG_HEIGHT - 1);
  localparam logic [RowW-1:0]   RowReload  = RowW'(IMG_HEIGHT - 2);
  localparam logic [ADDR_W:0]   PrimeBeats = (ADDR_W + 1)'(IMG_WIDTH + 1);

  // Luma
  logic [9:0] y_sum;
  logic [7:0] y;
  assign y_sum = {2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB};
  assign y     = y_sum[9:2];

  // Line buffers are addressed by a free-running pointer so they act as pure
  // IMG_WIDTH-beat delays, independent of where iSOF lands.
  logic [31:0]       lb1_mem [Depth];
  logic [7:0]        lb0_mem [Depth];
  logic [31:0]       lb1_rd;
  logic [7:0]        lb0_rd;
  logic [ADDR_W-1:0] wptr_q, wptr_d;

  assign lb1_rd = lb1_mem[wptr_q];
  assign lb0_rd = lb0_mem[wptr_q];

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb1_mem[wptr_q] <= {iR, iG, iB, y};
      lb0_mem[wptr_q] <= lb1_rd[7:0];
    end
  end

  // Window: win_q[row][col], row 0 = oldest line, col 0 = oldest column.
  logic [2:0][2:0][7:0] win_q, win_d;
  logic [1:0][23:0]     rgbw_q, rgbw_d;
  logic [ADDR_W:0]      prime_q, prime_d;
  logic                 primed;
  logic [RowW-1:0]      crow_q, crow_d, cur_row, nxt_row;
  logic [ADDR_W-1:0]    ccol_q, ccol_d, cur_col, nxt_col;
  logic                 s1_vld_q, s1_vld_d;
  logic [RowW-1:0]      s1_row_q, s1_row_d;
  logic [ADDR_W-1:0]    s1_col_q, s1_col_d;
  logic [7:0]           s1_thr_q, s1_thr_d;

  assign primed = (prime_q == PrimeBeats);

  // Centre position of the current beat; iSOF means the centre is (0,0) minus IMG_WIDTH+1.
  always_comb begin
    cur_row = iSOF ? RowReload : crow_q;
    cur_col = iSOF ? ColLast : ccol_q;
    if (cur_col == ColLast) begin
      nxt_col = '0;
      nxt_row = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
    end else begin
      nxt_col = cur_col + ADDR_W'(1);
      nxt_row = cur_row;
    end
  end

  always_comb begin
    win_d    = win_q;
    rgbw_d   = rgbw_q;
    wptr_d   = wptr_q;
    prime_d  = prime_q;
    crow_d   = crow_q;
    ccol_d   = ccol_q;
    s1_vld_d = 1'b0;
    s1_row_d = s1_row_q;
    s1_col_d = s1_col_q;
    s1_thr_d = s1_thr_q;
    if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd[7:0];
      win_d[2][2] = y;
      rgbw_d[0]   = rgbw_q[1];
      rgbw_d[1]   = lb1_rd[31:8];
      wptr_d      = (wptr_q == ColLast) ? '0 : wptr_q + ADDR_W'(1);
      if (!primed) prime_d = prime_q + (ADDR_W + 1)'(1);
      crow_d   = nxt_row;
      ccol_d   = nxt_col;
      s1_vld_d = primed;
      s1_row_d = cur_row;
      s1_col_d = cur_col;
      s1_thr_d = iTHRESH;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      win_q    <= '0;
      rgbw_q   <= '0;
      wptr_q   <= '0;
      prime_q  <= '0;
      crow_q   <= RowReload;
      ccol_q   <= ColLast;
      s1_vld_q <= 1'b0;
      s1_row_q <= '0;
      s1_col_q <= '0;
      s1_thr_q <= '0;
    end else begin
      win_q    <= win_d;
      rgbw_q   <= rgbw_d;
      wptr_q   <= wptr_d;
      prime_q  <= prime_d;
      crow_q   <= crow_d;
      ccol_q   <= ccol_d;
      s1_vld_q <= s1_vld_d;
      s1_row_q <= s1_row_d;
      s1_col_q <= s1_col_d;
      s1_thr_q <= s1_thr_d;
    end
  end

  // Sobel on the registered window; the window only moves on beats, so it is
  // still the one belonging to s1 in the cycle after it was captured.
  logic [9:0]         xr, xl, yb, yt;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        asum;
  logic [7:0]         mag;
  logic               border;
  logic               is_edge;

  always_comb begin
    xr   = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
    xl   = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    yb   = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
    yt   = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
    gx   = $signed({1'b0, xr}) - $signed({1'b0, xl});
    gy   = $signed({1'b0, yb}) - $signed({1'b0, yt});
    ax   = gx[10] ? -gx : gx;
    ay   = gy[10] ? -gy : gy;
    asum = {1'b0, ax} + {1'b0, ay};
    mag  = (asum[11:10] != 2'b00) ? 8'hFF : asum[9:2];
    border = (s1_row_q == '0) || (s1_row_q == RowLast) ||
             (s1_col_q == '0) || (s1_col_q == ColLast);
    is_edge = !border && (mag >= s1_thr_q);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oR    <= '0;
      oG    <= '0;
      oB    <= '0;
      oEDG  <= '0;
`ifdef EDGE_MAG_OUT_EN
      oMAG  <= '0;
`endif
    end else if (s1_vld_q) begin
      oDVAL <= 1'b1;
      oR    <= rgbw_q[0][23:16];
      oG    <= rgbw_q[0][15:8];
      oB    <= rgbw_q[0][7:0];
      oEDG  <= is_edge ? 8'hFF : 8'h00;
`ifdef EDGE_MAG_OUT_EN
      oMAG  <= border ? 8'h00 : mag;
`endif
    end else begin
      oDVAL <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_edge_det.sv
// Bench for sobel_edge_det: stream-level reference model plus hand-counted section totals.
module tb_sobel_edge_det;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk;
  logic       rst_n;
  logic       dval;
  logic       sof;
  logic [7:0] r, g, b, thr;
  logic       odval;
  logic [7:0] o_r, o_g, o_b, oedg;
`ifdef EDGE_MAG_OUT_EN
  logic [7:0] omag;
`endif

  sobel_edge_det #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (3)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iDVAL  (dval),
    .iSOF   (sof),
    .iR     (r),
    .iG     (g),
    .iB     (b),
    .iTHRESH(thr),
    .oDVAL  (odval),
    .oR     (o_r),
    .oG     (o_g),
    .oB     (o_b),
    .oEDG   (oedg)
`ifdef EDGE_MAG_OUT_EN
    ,
    .oMAG   (omag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         sec;
    logic [7:0] r, g, b, e, m;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   sec  = 9;
  int   edge_cnt = 0;
  int   b9_edge = -1;
  int   first_out0 = -1;
  int   sec_out[10], sec_edg[10], sec_m255[10], sec_m0[10], sec_rgb100[10];

  int   yh[4096];
  logic [23:0] rgbh[4096];
  int   nbeat, prevpos;
  logic [7:0] lr, lg, lb, le, lm;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int yat(input int i);
    return (i < 0) ? 0 : yh[i];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] pix(input int pat, input int rr, input int cc);
    logic [7:0] v;
    case (pat)
      0:       v = 8'd100;
      1:       v = (cc >= 4) ? 8'd255 : 8'd0;
      2:       v = ((rr + cc) % 2 == 1) ? 8'd255 : 8'd0;
      default: return {8'(cc * 30), 8'(rr * 40), 8'(255 - cc * 20)};
    endcase
    return {v, v, v};
  endfunction

  // Reference model (posedge) and the single compare point (negedge).
  initial begin : model_cmp
    exp_t x;
    int k, c, pos, cp, crow, ccol, gx, gy, m, cur;
    bit border;
    nbeat = 0; prevpos = W * H - 1;
    lr = 0; lg = 0; lb = 0; le = 0; lm = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        nbeat = 0;
        prevpos = W * H - 1;
      end else if (dval) begin
        k = nbeat;
        yh[k]   = (int'(r) + 2 * int'(g) + int'(b)) / 4;
        rgbh[k] = {r, g, b};
        pos = sof ? 0 : (prevpos + 1) % (W * H);
        prevpos = pos;
        if (sec == 0 && k == 9) b9_edge = edge_cnt;
        if (k >= W + 1) begin
          c  = k - W - 1;
          cp = (pos - (W + 1) + W * H) % (W * H);
          crow = cp / W;
          ccol = cp % W;
          gx = (yat(c - W + 1) + 2 * yat(c + 1) + yat(c + W + 1))
             - (yat(c - W - 1) + 2 * yat(c - 1) + yat(c + W - 1));
          gy = (yat(c + W - 1) + 2 * yat(c + W) + yat(c + W + 1))
             - (yat(c - W - 1) + 2 * yat(c - W) + yat(c - W + 1));
          m = (iabs(gx) + iabs(gy)) / 4;
          if (m > 255) m = 255;
          border = (crow == 0) || (crow == H - 1) || (ccol == 0) || (ccol == W - 1);
          x.due = edge_cnt + 1;
          x.sec = sec;
          x.r = rgbh[c][23:16];
          x.g = rgbh[c][15:8];
          x.b = rgbh[c][7:0];
          x.e = (!border && m >= int'(thr)) ? 8'd255 : 8'd0;
          x.m = border ? 8'd0 : 8'(m);
          q.push_back(x);
        end
        nbeat++;
      end
      edge_cnt++;

      @(negedge clk);
      cur = edge_cnt - 1;
      if (!rst_n) begin
        q.delete();
        lr = 0; lg = 0; lb = 0; le = 0; lm = 0;
        chk("reset_dval", odval, 0);
        chk("reset_outputs", {o_r, o_g, o_b, oedg}, 0);
`ifdef EDGE_MAG_OUT_EN
        chk("reset_mag", omag, 0);
`endif
      end else if (odval) begin
        if (q.size() == 0) begin
          chk("spurious_dval", 1, 0);
        end else begin
          x = q.pop_front();
          chk("latency", cur, x.due);
          chk("out_r", o_r, x.r);
          chk("out_g", o_g, x.g);
          chk("out_b", o_b, x.b);
          chk("out_edg", oedg, x.e);
`ifdef EDGE_MAG_OUT_EN
          chk("out_mag", omag, x.m);
          if (omag == 8'd255) sec_m255[x.sec]++;
          if (omag == 8'd0) sec_m0[x.sec]++;
`endif
          lr = x.r; lg = x.g; lb = x.b; le = x.e; lm = x.m;
          sec_out[x.sec]++;
          if (oedg == 8'd255) sec_edg[x.sec]++;
          if (o_r == 8'd100 && o_g == 8'd100 && o_b == 8'd100) sec_rgb100[x.sec]++;
          if (x.sec == 0 && first_out0 < 0) first_out0 = cur;
        end
      end else begin
        chk("hold", {o_r, o_g, o_b, oedg}, {lr, lg, lb, le});
`ifdef EDGE_MAG_OUT_EN
        chk("hold_mag", omag, lm);
`endif
        if (q.size() > 0 && q[0].due <= cur) begin
          chk("missed_dval", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send_range(input int pat, input int n, input int gap);
    logic [23:0] v;
    for (int i = 0; i < n; i++) begin
      v = pix(pat, (i / W) % H, i % W);
      dval = 1'b1;
      sof  = (i == 0);
      r = v[23:16]; g = v[15:8]; b = v[7:0];
      @(posedge clk); #1;
      dval = 1'b0;
      sof  = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 10; i++) begin
      sec_out[i] = 0; sec_edg[i] = 0; sec_m255[i] = 0; sec_m0[i] = 0; sec_rgb100[i] = 0;
    end
    rst_n = 1'b0; dval = 1'b0; sof = 1'b0; r = 0; g = 0; b = 0; thr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      dval = ~dval; sof = dval; r = 8'd77; g = 8'd88; b = 8'd99;
    end
    dval = 1'b0; sof = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    thr = 8'd1;   sec = 0; send_range(0, 48, 0);
    thr = 8'd128; sec = 1; send_range(1, 48, 0); send_range(1, 48, 0);
    sec = 2; send_range(1, 48, 2); send_range(1, 48, 2);
    thr = 8'd0;   sec = 3; send_range(2, 48, 0); send_range(2, 48, 0);
    thr = 8'd128; sec = 4; send_range(1, 21, 0);
    sec = 5; send_range(1, 48, 0);
    sec = 6; send_range(1, 48, 0);
    sec = 8; send_range(3, 20, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dval = ~dval;
      @(posedge clk); #1;
    end
    dval = 1'b0;
    rst_n = 1'b1;
    sec = 7; send_range(1, 48, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end

    chk("drain_queue", q.size(), 0);
    chk("beat10_latency", first_out0, b9_edge + 1);
    chk("flat_outputs", sec_out[0], 39);
    chk("flat_edges", sec_edg[0], 0);
    chk("flat_rgb100", sec_rgb100[0], 39);
    chk("step_outputs", sec_out[1], 96);
    chk("step_edges", sec_edg[1], 16);
    chk("gapped_outputs", sec_out[2], 96);
    chk("gapped_edges", sec_edg[2], 16);
    chk("checker_outputs", sec_out[3], 96);
    chk("checker_edges", sec_edg[3], 48);
    chk("resync_f1_outputs", sec_out[5], 48);
    chk("resync_f1_edges", sec_edg[5], 8);
    chk("resync_f2_edges", sec_edg[6], 8);
    chk("midreset_outputs", sec_out[7], 39);
    chk("midreset_edges", sec_edg[7], 8);
`ifdef EDGE_MAG_OUT_EN
    chk("step_mag255", sec_m255[1], 16);
    chk("step_mag0", sec_m0[1], 80);
    chk("resync_mag255", sec_m255[5], 8);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
